riscv_mdu_iter: RTL

Parametrised iterative multiply/divide unit implementing the RV M-extension operations. It sits beside the single-cycle integer ALU in the execute stage and is selected by the same func3 field. Operands are accepted over a valid/ready handshake. The unit computes the result over multiple cycles with a shared shift-add / restoring-divide datapath and holds it until the consumer takes it.

---
 rtl/riscv_mdu_iter_if.sv | 29 ++
 rtl/riscv_mdu_iter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/riscv_mdu_iter_if.sv
// Request/response bundle between the execute stage and the iterative multiply/divide unit.
// The execute stage is master; the MDU is slave.
interface riscv_mdu_iter_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       func3;
  logic [XLEN-1:0]  rs1;
  logic [XLEN-1:0]  rs2;
  logic [TAG_W-1:0] in_tag;
  logic             kill;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] out_tag;
  logic             dz;

  modport master (
    output in_valid, func3, rs1, rs2, in_tag, kill, out_ready,
    input  in_ready, out_valid, result, out_tag, dz
  );

  modport slave (
    input  in_valid, func3, rs1, rs2, in_tag, kill, out_ready,
    output in_ready, out_valid, result, out_tag, dz
  );
endinterface

// File: rtl/riscv_mdu_iter.sv
// Iterative RV M-extension unit: one bit per cycle shift-add multiply / restoring divide
// on operand magnitudes, followed by a sign-fix cycle and a held result.
module riscv_mdu_iter #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input logic            clk,
  input logic            rst,
  riscv_mdu_iter_if.slave mdu
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [2:0]         op;
  logic [TAG_W-1:0]   tag;
  logic               sgn1;
  logic               sgn2;
  logic [XLEN-1:0]    opb;
  logic [2*XLEN:0]    acc;

  logic               s1_c, s2_c, div_zero_c, ovf_c;
  logic [XLEN-1:0]    mag1_c, mag2_c, special_c;
  logic [XLEN:0]      mul_sum_c, div_shift_c;
  logic [XLEN+1:0]    div_diff_c;
  logic [2*XLEN:0]    acc_next_c;
  logic [2*XLEN-1:0]  prod_fix_c;
  logic [XLEN-1:0]    fix_res_c;

  // Accept-time decode: operand signs, magnitudes and the two shortcut cases
  always_comb begin
    s1_c       = 1'b0;
    s2_c       = 1'b0;
    case (mdu.func3)
      3'd1, 3'd4, 3'd6: begin s1_c = mdu.rs1[XLEN-1]; s2_c = mdu.rs2[XLEN-1]; end
      3'd2:             s1_c = mdu.rs1[XLEN-1];
      default:          ;
    endcase
    mag1_c     = s1_c ? -mdu.rs1 : mdu.rs1;
    mag2_c     = s2_c ? -mdu.rs2 : mdu.rs2;
    div_zero_c = mdu.func3[2] && (mdu.rs2 == '0);
    ovf_c      = mdu.func3[2] && !mdu.func3[0] && (mdu.rs1 == MIN_NEG) && (mdu.rs2 == '1);
    special_c  = '0;
    if (div_zero_c)
      special_c = mdu.func3[1] ? mdu.rs1 : '1;
    else if (ovf_c)
      special_c = mdu.func3[1] ? '0 : mdu.rs1;
  end

  // One iteration: acc holds {hi, lo}; multiply shifts right, divide shifts left
  always_comb begin
    mul_sum_c   = acc[2*XLEN:XLEN] + (acc[0] ? {1'b0, opb} : '0);
    div_shift_c = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff_c  = {1'b0, div_shift_c} - {2'b00, opb};
    acc_next_c  = {1'b0, mul_sum_c, acc[XLEN-1:1]};
    if (op[2])
      acc_next_c = {(div_diff_c[XLEN+1] ? div_shift_c : div_diff_c[XLEN:0]),
                    acc[XLEN-2:0], ~div_diff_c[XLEN+1]};
  end

  // Sign correction and result select
  always_comb begin
    prod_fix_c = (sgn1 ^ sgn2) ? -acc[2*XLEN-1:0] : acc[2*XLEN-1:0];
    fix_res_c  = '0;
    case (op)
      3'd0:             fix_res_c = prod_fix_c[XLEN-1:0];
      3'd1, 3'd2, 3'd3: fix_res_c = prod_fix_c[2*XLEN-1:XLEN];
      3'd4, 3'd5:       fix_res_c = (sgn1 ^ sgn2) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      default:          fix_res_c = sgn1 ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      count         <= '0;
      op            <= '0;
      tag           <= '0;
      sgn1          <= 1'b0;
      sgn2          <= 1'b0;
      opb           <= '0;
      acc           <= '0;
      mdu.in_ready  <= 1'b1;
      mdu.out_valid <= 1'b0;
      mdu.result    <= '0;
      mdu.out_tag   <= '0;
      mdu.dz        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mdu.in_valid && !mdu.kill) begin
            op           <= mdu.func3;
            tag          <= mdu.in_tag;
            sgn1         <= s1_c;
            sgn2         <= s2_c;
            count        <= '0;
            mdu.in_ready <= 1'b0;
            if (div_zero_c || ovf_c) begin
              mdu.result    <= special_c;
              mdu.out_tag   <= mdu.in_tag;
              mdu.dz        <= div_zero_c;
              mdu.out_valid <= 1'b1;
              state         <= DONE;
            end else begin
              opb   <= mdu.func3[2] ? mag2_c : mag1_c;
              acc   <= {{(XLEN+1){1'b0}}, (mdu.func3[2] ? mag1_c : mag2_c)};
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (mdu.kill) begin
            mdu.in_ready <= 1'b1;
            state        <= IDLE;
          end else begin
            acc   <= acc_next_c;
            count <= count + CW'(1);
            if (count == CW'(XLEN-1))
              state <= FIX;
          end
        end
        FIX: begin
          if (mdu.kill) begin
            mdu.in_ready <= 1'b1;
            state        <= IDLE;
          end else begin
            mdu.result    <= fix_res_c;
            mdu.out_tag   <= tag;
            mdu.dz        <= 1'b0;
            mdu.out_valid <= 1'b1;
            state         <= DONE;
          end
        end
        default: begin
          if (mdu.kill || mdu.out_ready) begin
            mdu.out_valid <= 1'b0;
            mdu.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
